// File: rtl/ats_pkg.sv
// ats_pkg: shared command-frame types, field positions and helpers for the
// ats_timer_bank alarm/timer engine.
package ats_pkg;

  localparam int CMD_W    = 16;          // one command beat
  localparam int FRAME_W  = 2 * CMD_W;   // upper beat followed by lower beat
  localparam int CLK_LSB  = 9;           // clock index for clock commands, U[12:9]
  localparam int CLK_W    = 4;
  localparam int RATE_LSB = 6;           // prescaler rate, U[7:6]
  localparam int TMR_W    = 5;           // timer index, U[12:8]
  localparam int ACLK_W   = 4;           // clock a timer is bound to, U[3:0]

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_CLK_EN  = 3'b010,
    OP_ILL3    = 3'b011,
    OP_ILL4    = 3'b100,
    OP_SET_ALM = 3'b101,
    OP_SET_CD  = 3'b110,
    OP_TMR_EN  = 3'b111
  } ats_op_e;

  typedef enum logic [1:0] {
    RATE_DIV1 = 2'd0,
    RATE_DIV2 = 2'd1,
    RATE_DIV4 = 2'd2,
    RATE_DIV8 = 2'd3
  } ats_rate_e;

  // Upper command beat; clock commands reuse tmr[4:1] as the clock index
  // and {flag, mid[2]} as the rate.
  typedef struct packed {
    ats_op_e           op;
    logic [TMR_W-1:0]  tmr;
    logic              flag;
    logic [2:0]        mid;
    logic [ACLK_W-1:0] aclk;
  } ats_upper_t;

  // Prescaler terminal count for a rate: a tick happens every 2^r cycles.
  function automatic logic [2:0] pre_max(ats_rate_e r);
    case (r)
      RATE_DIV1: pre_max = 3'd0;
      RATE_DIV2: pre_max = 3'd1;
      RATE_DIV4: pre_max = 3'd3;
      default:   pre_max = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/ats_cmd_rx.sv
// ats_cmd_rx: req strobe plus two-beat command receiver. Captures the upper
// and lower beats, then raises exec for one cycle with the assembled frame.
module ats_cmd_rx
  import ats_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic [CMD_W-1:0]   ctrl_i,
  output logic               busy_o,
  output logic               exec_o,
  output logic               req_err_o,
  output logic [FRAME_W-1:0] frame_o
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_EXEC} rx_state_e;

  rx_state_e        state_q, state_d;
  logic [CMD_W-1:0] upper_q, upper_d;
  logic [CMD_W-1:0] lower_q, lower_d;

  // State and captured beats; reset discards any partial command
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      upper_q <= '0;
      lower_q <= '0;
    end else begin
      state_q <= state_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
    end
  end

  // Beat sequencing; a req arriving while busy is dropped and flagged
  always_comb begin
    state_d   = state_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    busy_o    = (state_q != S_IDLE);
    exec_o    = 1'b0;
    req_err_o = req_i && (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (req_i) state_d = S_BEAT1;
      S_BEAT1: begin
        upper_d = ctrl_i;
        state_d = S_BEAT2;
      end
      S_BEAT2: begin
        lower_d = ctrl_i;
        state_d = S_EXEC;
      end
      default: begin
        exec_o  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_o = {upper_q, lower_q};

endmodule

// File: rtl/ats_timer_bank.sv
// ats_timer_bank: N_CLK prescaled virtual clocks driving N_TMR alarm or
// countdown timers, with expiries reported lowest-index-first on a
// valid/ready event port. Optional feature macro ATS_EVT_TIMESTAMP_EN adds
// per-timer expiry timestamps on evt_time (tied to 0 otherwise).
module ats_timer_bank
  import ats_pkg::*;
#(
  parameter  int N_CLK  = 4,
  parameter  int N_TMR  = 8,
  parameter  int TIME_W = 16,
  localparam int ID_W   = (N_TMR > 1) ? $clog2(N_TMR) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [15:0]       ctrl,
  output logic              busy,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [TIME_W-1:0] evt_time,
  output logic [1:0]        stat
);

  localparam int CK_IW = (N_CLK > 1) ? $clog2(N_CLK) : 1;

  logic               exec, req_err, cmd_err, cmd_ok, tmr_op, unused_bits;
  logic [FRAME_W-1:0] frame;
  ats_upper_t         up;
  logic [CLK_W-1:0]   cmd_clk;
  ats_rate_e          cmd_rate;
  logic [TIME_W-1:0]  cmd_val;

  // Clock state
  logic [N_CLK-1:0]  cen_q, cen_d, tick;
  ats_rate_e         crate_q [N_CLK];
  ats_rate_e         crate_d [N_CLK];
  logic [2:0]        cpre_q [N_CLK];
  logic [2:0]        cpre_d [N_CLK];
  logic [TIME_W-1:0] ctime_q [N_CLK];
  logic [TIME_W-1:0] ctime_d [N_CLK];
  logic [TIME_W-1:0] ctime_nx [N_CLK];

  // Timer state; tcd marks countdown mode, tval holds alarm value or interval
  logic [N_TMR-1:0]  ten_q, ten_d, tcd_q, tcd_d, trep_q, trep_d;
  logic [N_TMR-1:0]  pend_q, pend_d, fire, hs_clr;
  logic [CK_IW-1:0]  tclk_q [N_TMR];
  logic [CK_IW-1:0]  tclk_d [N_TMR];
  logic [TIME_W-1:0] tval_q [N_TMR];
  logic [TIME_W-1:0] tval_d [N_TMR];
  logic [TIME_W-1:0] trem_q [N_TMR];
  logic [TIME_W-1:0] trem_d [N_TMR];
  logic              ovr;
  logic [1:0]        stat_q, stat_d;

  ats_cmd_rx u_rx (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (req),
    .ctrl_i    (ctrl),
    .busy_o    (busy),
    .exec_o    (exec),
    .req_err_o (req_err),
    .frame_o   (frame)
  );

  assign up          = ats_upper_t'(frame[FRAME_W-1:CMD_W]);
  assign cmd_clk     = frame[CMD_W+CLK_LSB +: CLK_W];
  assign cmd_rate    = ats_rate_e'(frame[CMD_W+RATE_LSB +: 2]);
  assign cmd_val     = frame[TIME_W-1:0];
  assign unused_bits = ^{frame, up};
  assign tmr_op      = (up.op == OP_SET_ALM) || (up.op == OP_SET_CD) || (up.op == OP_TMR_EN);
  assign cmd_ok      = exec && !cmd_err;

  // Validate the frame being executed; an error blocks every state update
  always_comb begin
    cmd_err = 1'b0;
    if (exec) begin
      case (up.op)
        OP_NOP:                cmd_err = 1'b0;
        OP_SET_CLK, OP_CLK_EN: cmd_err = (int'(cmd_clk) >= N_CLK);
        OP_SET_ALM:            cmd_err = (int'(up.tmr) >= N_TMR) || (int'(up.aclk) >= N_CLK);
        OP_SET_CD:             cmd_err = (int'(up.tmr) >= N_TMR) || (int'(up.aclk) >= N_CLK) ||
                                         (cmd_val == '0);
        OP_TMR_EN:             cmd_err = (int'(up.tmr) >= N_TMR);
        default:               cmd_err = 1'b1;
      endcase
    end
  end

  // Prescalers and clock times; clock commands override the tick update
  always_comb begin
    for (int c = 0; c < N_CLK; c++) begin
      cen_d[c]    = cen_q[c];
      crate_d[c]  = crate_q[c];
      cpre_d[c]   = cpre_q[c];
      ctime_d[c]  = ctime_q[c];
      tick[c]     = cen_q[c] && (cpre_q[c] == pre_max(crate_q[c]));
      ctime_nx[c] = ctime_q[c] + TIME_W'(1);
      if (tick[c]) begin
        cpre_d[c]  = '0;
        ctime_d[c] = ctime_nx[c];
      end else if (cen_q[c]) begin
        cpre_d[c] = cpre_q[c] + 3'd1;
      end
      if (cmd_ok && (int'(cmd_clk) == c)) begin
        if (up.op == OP_SET_CLK) begin
          crate_d[c] = cmd_rate;
          cpre_d[c]  = '0;
          ctime_d[c] = '0;
        end else if (up.op == OP_CLK_EN) begin
          cen_d[c] = up.flag;
        end
      end
    end
  end

  // Timer expiry, command writes (which suppress a same-cycle fire),
  // pending flags and overrun detection
  always_comb begin
    ovr = 1'b0;
    for (int t = 0; t < N_TMR; t++) begin
      ten_d[t]  = ten_q[t];
      tcd_d[t]  = tcd_q[t];
      trep_d[t] = trep_q[t];
      tclk_d[t] = tclk_q[t];
      tval_d[t] = tval_q[t];
      trem_d[t] = trem_q[t];
      fire[t]   = 1'b0;
      if (ten_q[t] && tick[tclk_q[t]]) begin
        if (tcd_q[t]) begin
          if (trem_q[t] <= TIME_W'(1)) begin
            fire[t]   = 1'b1;
            trem_d[t] = tval_q[t];
          end else begin
            trem_d[t] = trem_q[t] - TIME_W'(1);
          end
        end else if (ctime_nx[tclk_q[t]] == tval_q[t]) begin
          fire[t] = 1'b1;
          if (!trep_q[t]) ten_d[t] = 1'b0;
        end
      end
      if (cmd_ok && tmr_op && (int'(up.tmr) == t)) begin
        fire[t] = 1'b0;
        if (up.op == OP_TMR_EN) begin
          ten_d[t] = up.flag;
          if (up.flag && tcd_q[t]) trem_d[t] = tval_q[t];
        end else begin
          ten_d[t]  = 1'b0;
          tcd_d[t]  = (up.op == OP_SET_CD);
          trep_d[t] = up.flag;
          tclk_d[t] = up.aclk[CK_IW-1:0];
          tval_d[t] = cmd_val;
        end
      end
      hs_clr[t] = evt_valid && evt_ready && (int'(evt_id) == t);
      pend_d[t] = (pend_q[t] && !hs_clr[t]) || fire[t];
      if (fire[t] && pend_q[t] && !hs_clr[t]) ovr = 1'b1;
    end
  end

  // Sticky status: NOP with U[0] clears, new errors and overruns set
  always_comb begin
    stat_d = stat_q;
    if (cmd_ok && (up.op == OP_NOP) && up.aclk[0]) stat_d = 2'b00;
    stat_d[0] = stat_d[0] | cmd_err | req_err;
    stat_d[1] = stat_d[1] | ovr;
  end

  // Lowest pending timer is reported first
  always_comb begin
    evt_id = '0;
    for (int t = N_TMR - 1; t >= 0; t--) begin
      if (pend_q[t]) evt_id = ID_W'(t);
    end
  end

  assign evt_valid = |pend_q;
  assign stat      = stat_q;

  // Register all clock, timer and status state
  always_ff @(posedge clk) begin
    if (!reset) begin
      cen_q  <= '0;
      ten_q  <= '0;
      tcd_q  <= '0;
      trep_q <= '0;
      pend_q <= '0;
      stat_q <= 2'b00;
      for (int c = 0; c < N_CLK; c++) begin
        crate_q[c] <= RATE_DIV1;
        cpre_q[c]  <= '0;
        ctime_q[c] <= '0;
      end
      for (int t = 0; t < N_TMR; t++) begin
        tclk_q[t] <= '0;
        tval_q[t] <= '0;
        trem_q[t] <= '0;
      end
    end else begin
      cen_q  <= cen_d;
      ten_q  <= ten_d;
      tcd_q  <= tcd_d;
      trep_q <= trep_d;
      pend_q <= pend_d;
      stat_q <= stat_d;
      for (int c = 0; c < N_CLK; c++) begin
        crate_q[c] <= crate_d[c];
        cpre_q[c]  <= cpre_d[c];
        ctime_q[c] <= ctime_d[c];
      end
      for (int t = 0; t < N_TMR; t++) begin
        tclk_q[t] <= tclk_d[t];
        tval_q[t] <= tval_d[t];
        trem_q[t] <= trem_d[t];
      end
    end
  end

`ifdef ATS_EVT_TIMESTAMP_EN
  logic [TIME_W-1:0] tstamp_q [N_TMR];

  // Latch the bound clock's new time whenever a timer fires
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int t = 0; t < N_TMR; t++) tstamp_q[t] <= '0;
    end else begin
      for (int t = 0; t < N_TMR; t++) begin
        if (fire[t]) tstamp_q[t] <= ctime_nx[tclk_q[t]];
      end
    end
  end

  assign evt_time = tstamp_q[evt_id];
`else
  assign evt_time = '0;
`endif

endmodule
